// File: rtl/glove_pkg.sv
// Shared types and default timing constants for the glove tracker.
// Timing defaults assume a 65 MHz system clock.
package glove_pkg;

    localparam int COORD_W             = 16;
    localparam int CLK_HZ              = 65_000_000;
    localparam int DEF_TIMEOUT_CYCLES  = CLK_HZ / 10;
    localparam int DEF_COOLDOWN_CYCLES = CLK_HZ / 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_STALE = 2'd2
    } glove_state_e;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic coord_t abs_diff(input coord_t a, input coord_t b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/glove_avg.sv
// Boxcar average of one coordinate axis: ring buffer of 2**AVG_LOG2 samples
// plus a running sum, so each push costs one add and one subtract.
module glove_avg
    import glove_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               preload,
    input  logic               push,
    input  logic [COORD_W-1:0] din,
    output logic [COORD_W-1:0] dout
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = COORD_W + AVG_LOG2;

    logic [COORD_W-1:0]  ring_q [N];
    logic [COORD_W-1:0]  ring_d [N];
    logic [AVG_LOG2-1:0] ptr_q, ptr_d;
    logic [SW-1:0]       sum_q, sum_d;

    always_comb begin
        ring_d = ring_q;
        ptr_d  = ptr_q;
        sum_d  = sum_q;
        if (preload) begin
            for (int i = 0; i < N; i++) begin
                ring_d[i] = din;
            end
            ptr_d = '0;
            sum_d = SW'(din) << AVG_LOG2;
        end else if (push) begin
            // The sum can never exceed N * max(din), so SW bits never overflow.
            ring_d[ptr_q] = din;
            ptr_d         = ptr_q + AVG_LOG2'(1);
            sum_d         = sum_q + SW'(din) - SW'(ring_q[ptr_q]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                ring_q[i] <= '0;
            end
            ptr_q <= '0;
            sum_q <= '0;
        end else begin
            ring_q <= ring_d;
            ptr_q  <= ptr_d;
            sum_q  <= sum_d;
        end
    end

    assign dout = COORD_W'(sum_q >> AVG_LOG2);

endmodule

// File: rtl/glove_tracker.sv
// Glove sensor front end: filtered position, debounced closed flag, catch cooldown.
// Optional outlier rejection is built when GLOVE_TRACKER_OUTLIER_EN is defined.
module glove_tracker
    import glove_pkg::*;
#(
    parameter int AVG_LOG2         = 2,
    parameter int DEBOUNCE_SAMPLES = 3,
    parameter int MAX_JUMP         = 500,
    parameter int REJECT_LIMIT     = 3,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
    parameter int COOLDOWN_CYCLES  = DEF_COOLDOWN_CYCLES
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sample_valid,
    input  logic [COORD_W-1:0] raw_x,
    input  logic [COORD_W-1:0] raw_y,
    input  logic               raw_closed,
    input  logic               held,
    input  logic               throw_event,
    output logic [COORD_W-1:0] glove_x,
    output logic [COORD_W-1:0] glove_y,
    output logic               glove_closed,
    output logic               can_catch,
    output logic               pos_valid,
    output logic [1:0]         dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);

    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] DBC_LAST  = DW'(DEBOUNCE_SAMPLES - 1);
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_CYCLES);

    glove_state_e  state_q, state_d;
    logic          preload, push;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          closed_q, closed_d;
    logic [DW-1:0] dbc_q, dbc_d;
    logic [CW-1:0] cool_q, cool_d;
    logic          can_q, can_d;
    logic          held_dly_q, held_dly_d;
    logic          thr_dly_q, thr_dly_d;

`ifdef GLOVE_TRACKER_OUTLIER_EN
    localparam int                 RW         = $clog2(REJECT_LIMIT + 1);
    localparam logic [RW-1:0]      REJ_LAST   = RW'(REJECT_LIMIT - 1);
    localparam logic [COORD_W-1:0] MAX_JUMP_C = COORD_W'(MAX_JUMP);

    logic [RW-1:0] rej_q, rej_d;
    logic          outlier;

    assign outlier = (abs_diff(raw_x, glove_x) > MAX_JUMP_C) ||
                     (abs_diff(raw_y, glove_y) > MAX_JUMP_C);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rej_q <= '0;
        end else begin
            rej_q <= rej_d;
        end
    end
`else
    localparam int outlier_cfg_unused = MAX_JUMP + REJECT_LIMIT;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        preload = 1'b0;
        push    = 1'b0;
        tmo_d   = tmo_q;
`ifdef GLOVE_TRACKER_OUTLIER_EN
        rej_d   = rej_q;
`endif
        if (sample_valid) begin
            // A sample always wins over a coincident timeout expiry.
            tmo_d   = '0;
            state_d = ST_TRACK;
            if (state_q != ST_TRACK) begin
                preload = 1'b1;
`ifdef GLOVE_TRACKER_OUTLIER_EN
                rej_d   = '0;
            end else if (!outlier) begin
                push  = 1'b1;
                rej_d = '0;
            end else if (rej_q == REJ_LAST) begin
                preload = 1'b1;
                rej_d   = '0;
            end else begin
                rej_d = rej_q + RW'(1);
            end
`else
            end else begin
                push = 1'b1;
            end
`endif
        end else if (state_q == ST_TRACK) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_STALE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_comb begin
        pos_valid = (state_q == ST_TRACK);
        dbg_state = state_q;
    end

    always_comb begin
        closed_d   = closed_q;
        dbc_d      = dbc_q;
        held_dly_d = held;
        thr_dly_d  = throw_event;
        if (sample_valid) begin
            if (raw_closed != closed_q) begin
                if (dbc_q == DBC_LAST) begin
                    closed_d = ~closed_q;
                    dbc_d    = '0;
                end else begin
                    dbc_d = dbc_q + DW'(1);
                end
            end else begin
                dbc_d = '0;
            end
        end
        // held has already dropped when throw_event rises, so the delayed copy qualifies it.
        if (throw_event && !thr_dly_q && held_dly_q) begin
            cool_d = COOL_LOAD;
        end else if (cool_q != '0) begin
            cool_d = cool_q - CW'(1);
        end else begin
            cool_d = '0;
        end
        can_d = (state_d == ST_TRACK) && !held && (cool_d == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q      <= '0;
            closed_q   <= 1'b0;
            dbc_q      <= '0;
            cool_q     <= '0;
            can_q      <= 1'b0;
            held_dly_q <= 1'b0;
            thr_dly_q  <= 1'b0;
        end else begin
            tmo_q      <= tmo_d;
            closed_q   <= closed_d;
            dbc_q      <= dbc_d;
            cool_q     <= cool_d;
            can_q      <= can_d;
            held_dly_q <= held_dly_d;
            thr_dly_q  <= thr_dly_d;
        end
    end

    assign glove_closed = closed_q;
    assign can_catch    = can_q;

    glove_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_x (
        .clk     (clk),
        .reset_n (reset_n),
        .preload (preload),
        .push    (push),
        .din     (raw_x),
        .dout    (glove_x)
    );

    glove_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_y (
        .clk     (clk),
        .reset_n (reset_n),
        .preload (preload),
        .push    (push),
        .din     (raw_y),
        .dout    (glove_y)
    );

endmodule

// File: doc/glove_tracker.md
Name: glove_tracker

Overview:
- Producer side of the glove interface consumed by the ball state machine; one instance per glove.
- Converts raw hand-sensor samples (mm coordinates plus a closed flag) into a filtered glove position, a debounced closed level and a can_catch qualifier.
- Watches the ball machine's throw_event and held status to enforce a post-throw catch cooldown.
- Sits between the camera/hand-detection front end and the ball state machine.

Parameters:
- AVG_LOG2, 2, log2 of boxcar averaging depth (N = 4 samples)
- DEBOUNCE_SAMPLES, 3, consecutive disagreeing valid samples needed to flip glove_closed
- MAX_JUMP, 500, mm; a per-axis step larger than this from the current glove position is an outlier
- REJECT_LIMIT, 3, consecutive outliers that force re-acquisition at the new position
- TIMEOUT_CYCLES, 6500000, clk cycles without sample_valid before the position goes stale (0.1 s at 65 MHz)
- COOLDOWN_CYCLES, 16250000, clk cycles can_catch stays low after this glove throws (0.25 s)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sample_valid  in  1  one-cycle strobe; raw_* valid this cycle
- raw_x  in  16  raw glove x, mm
- raw_y  in  16  raw glove y, mm
- raw_closed  in  1  raw hand-closed flag
- held  in  1  ball currently held by this glove (ball_state equals this glove's index)
- throw_event  in  1  throw pulse from ball machine, stretched over several cycles
- glove_x  out  16  filtered x, mm
- glove_y  out  16  filtered y, mm
- glove_closed  out  1  debounced closed level
- can_catch  out  1  glove is eligible to catch
- pos_valid  out  1  position is tracked and fresh

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: glove_x = 0, glove_y = 0, glove_closed = 0, can_catch = 0, pos_valid = 0. Reset also clears all counters, the ring buffer and the sums, and sets state to IDLE. Reset asserted mid-operation aborts everything immediately.
- States:
  - IDLE: no sample seen yet.
  - TRACK: position is being tracked.
  - STALE: timeout expired.
- Outputs registered; all updates take effect 1 cycle after sample_valid.
- IDLE or STALE, on sample_valid: preload all N ring slots with the raw value; sum = raw << AVG_LOG2; glove_x/y = raw; go to TRACK.
- TRACK, on sample_valid with an accepted sample:
  - write raw into the slot at the write pointer; pointer wraps modulo N;
  - sum = sum + raw - evicted slot, computed in 16+AVG_LOG2 bits, unsigned;
  - glove_x/y = sum >> AVG_LOG2 (truncating);
  - reject counter cleared.
- Outlier: |raw_x - glove_x| > MAX_JUMP or |raw_y - glove_y| > MAX_JUMP, using an unsigned magnitude compare. An outlier sample is dropped and the reject counter increments. When the counter reaches REJECT_LIMIT, that sample is preloaded as in IDLE and the counter clears.
- Timeout counter clears on every sample_valid, accepted or not. In TRACK, reaching TIMEOUT_CYCLES moves to STALE. glove_x/y hold their last values in STALE.
- pos_valid = 1 only in TRACK.
- Debounce:
  - Runs on every sample_valid in all states, independent of outlier status.
  - raw_closed != glove_closed: counter increments; at DEBOUNCE_SAMPLES, glove_closed toggles and the counter clears.
  - raw_closed == glove_closed: counter clears.
- Cooldown:
  - held_d = held delayed 1 cycle. The ball machine drops ball_state in the same edge that raises throw_event, so held_d is the qualifier.
  - Load cooldown = COOLDOWN_CYCLES on throw_event & ~throw_event_d & held_d.
  - Decrement to 0, saturating.
  - A new throw during cooldown reloads the counter.
- can_catch (registered) = pos_valid & ~held & (cooldown == 0).
- Simultaneous sample_valid and timeout expiry in the same cycle: the sample wins, and the block stays in TRACK.

Optional Feature:
- Macro: GLOVE_TRACKER_OUTLIER_EN.
- Defined: outlier rejection and re-acquisition behave as above.
- Undefined: every sample in TRACK is accepted; the reject counter and the comparators are not built; REJECT_LIMIT is unused.

Decomposition:
- Shared package glove_pkg holds:
  - state encoding (IDLE = 2'd0, TRACK = 2'd1, STALE = 2'd2);
  - mm coordinate width (16);
  - the default timing constants (65 MHz clock-derived TIMEOUT/COOLDOWN values).
- Sub-module glove_avg: ring buffer plus running sum for one axis, instantiated twice (x, y). Ports: preload, push, din, dout.

Test Plan (sim overrides: TIMEOUT_CYCLES = 50, COOLDOWN_CYCLES = 20):
- Reset, first sample (1000, 2000) -> next cycle glove = (1000, 2000), pos_valid = 1, can_catch = 1.
- From (1000, 1000), samples x = 1100, 1100, 1100, 1100 -> glove_x = 1025, 1050, 1075, 1100.
- From (1000, 1000), single sample x = 3000 -> glove_x stays 1000. Three consecutive 3000 -> glove_x = 3000 one cycle after the third sample. With macro undefined, the first 3000 gives glove_x = 1500.
- raw_closed = 1 for 2 samples then 0 -> glove_closed stays 0. 3 consecutive samples of 1 -> glove_closed = 1.
- held = 1, then held = 0 together with throw_event high for 6 cycles -> can_catch = 0 for 20 cycles, then returns to 1. A throw_event with held_d = 0 -> no cooldown.
- No sample for 50 cycles -> pos_valid = 0, can_catch = 0. Next sample (500, 600) -> glove = (500, 600), pos_valid = 1.
